huff_frame_ctrl: RTL

HUFF_FRAME_CTRL -- requirements
Module: huff_frame_ctrl

---
 rtl/huff_frame_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/huff_frame_ctrl.sv
// Frame controller feeding a Huffman decoder one nibble at a time from packed 16-bit words.
// Optional idle-symbol timeout is built only when HUFF_CTRL_TIMEOUT_EN is defined.
module huff_frame_ctrl #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic [15:0] cfg_nsym,
   input  logic        w_valid,
   input  logic [15:0] w_data,
   output logic        w_ready,
   input  logic        dec_aready,
   output logic        dec_svalid,
   output logic [3:0]  dec_data,
   output logic [2:0]  dec_len,
   input  logic        dec_tvalid,
   output logic        dec_flush,
   output logic        busy,
   output logic        done,
   output logic [15:0] sym_count,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FEED, S_FINISH} state_t;

   state_t      state_q, state_d;
   logic [15:0] nsym_q, nsym_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] sym_count_q, sym_count_d;
   logic [1:0]  k_q, k_d;
   logic        finish_q, finish_d;
   logic        busy_w;
   logic [3:0]  nibble_w;

   assign busy_w = (state_q == S_FETCH) || (state_q == S_FEED);

`ifdef HUFF_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
`else
   logic unused_tmo_param;
   assign unused_tmo_param = (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d     = state_q;
      nsym_d      = nsym_q;
      hold_d      = hold_q;
      sym_count_d = sym_count_q;
      k_d         = k_q;
      finish_d    = (state_q == S_FINISH);
`ifdef HUFF_CTRL_TIMEOUT_EN
      tmo_d = tmo_q;
      err_d = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               nsym_d      = cfg_nsym;
               sym_count_d = 16'd0;
               state_d     = (cfg_nsym == 16'd0) ? S_FINISH : S_FETCH;
`ifdef HUFF_CTRL_TIMEOUT_EN
               tmo_d = '0;
               err_d = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            if (w_valid) begin
               hold_d  = w_data;
               k_d     = 2'd0;
               state_d = S_FEED;
            end
         end
         S_FEED: begin
            if (dec_aready) begin
               k_d = k_q + 2'd1;
               if (k_q == 2'd3) state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (busy_w && dec_tvalid && (sym_count_q != nsym_q))
         sym_count_d = sym_count_q + 16'd1;

`ifdef HUFF_CTRL_TIMEOUT_EN
      if (busy_w) begin
         tmo_d = dec_tvalid ? '0 : tmo_q + 1'b1;
         if (tmo_d == TW'(TIMEOUT_CYC)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
         end
      end
`endif

      // Completion overrides any word or nibble transfer in the same cycle.
      if (busy_w && (sym_count_d == nsym_q))
         state_d = S_FINISH;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         nsym_q      <= 16'd0;
         hold_q      <= 16'd0;
         sym_count_q <= 16'd0;
         k_q         <= 2'd0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         nsym_q      <= nsym_d;
         hold_q      <= hold_d;
         sym_count_q <= sym_count_d;
         k_q         <= k_d;
         finish_q    <= finish_d;
      end
   end

`ifdef HUFF_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      case (k_q)
         2'd0:    nibble_w = hold_q[15:12];
         2'd1:    nibble_w = hold_q[11:8];
         2'd2:    nibble_w = hold_q[7:4];
         default: nibble_w = hold_q[3:0];
      endcase
   end

   assign w_ready    = (state_q == S_FETCH);
   assign dec_svalid = (state_q == S_FEED);
   assign dec_data   = (state_q == S_FEED) ? nibble_w : 4'd0;
   assign dec_len    = (state_q == S_FEED) ? 3'd4 : 3'd0;
   assign busy       = busy_w;
   assign done       = finish_q;
   assign dec_flush  = finish_q;
   assign sym_count  = sym_count_q;

endmodule
